shift_add_multiplier: RTL and testbench
=======================================

// Module: shift_add_multiplier
// PURPOSE
//  Sequential signed WIDTH x WIDTH -> 2*WIDTH multiplier using shift-and-add over sign-magnitude operands.
//  One product bit-step per clock; start/done handshake. Small-area alternative to array/Booth
//  multipliers in the multiplier-comparison datapath.
// PARAMETERS
//  WIDTH  32  operand width in bits; product is 2*WIDTH bits
// PORTS
//  clk           in   1        rising-edge clock
//  rst           in   1        reset, asynchronous, active-low (0 = reset)
//  start         in   1        begin multiply; sampled on rising clk, honoured only in IDLE
//  multiplicand  in   WIDTH    signed two's-complement operand A
//  multiplier    in   WIDTH    signed two's-complement operand B
//  product       out  2*WIDTH  signed two's-complement A*B, held until next accepted start
//  done          out  1        one-cycle pulse: product/overflow valid
//  overflow      out  1        product not representable as WIDTH-bit signed; valid with done, held
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, product=0, done=0, overflow=0, internal regs cleared. Reset
//    mid-operation aborts the multiply; no done is produced.
//  - States: IDLE -> CALC -> DONE -> IDLE.
//  - IDLE: start=1 at edge E0 latches |A|, |B| (WIDTH+1-bit magnitude so -2^(WIDTH-1) is exact),
//    result sign = A[W-1]^B[W-1]; accumulator cleared, counter=0; go CALC.
//  - CALC: each edge: if multiplier-magnitude LSB=1, acc += multiplicand-magnitude << count
//    (equivalently add-then-right-shift); counter++. Exactly WIDTH iterations (edges E1..E32).
//  - DONE entry (edge E33): product = sign ? -acc : acc (2*WIDTH bits); overflow computed;
//    done=1 for that cycle only. Next edge: done=0, return IDLE. product/overflow hold.
//  - Latency: done high in cycle after edge E(WIDTH+1); new start accepted the cycle after done.
//  - start while CALC/DONE ignored; operand inputs only sampled at acceptance.
//  - Zero result always +0 (never negative zero issue; sign irrelevant when acc=0).
//  - overflow=1 iff product[2W-1:W-1] not all equal bits.
//  - Boundaries: (-2^31)*1 = 64'hFFFFFFFF80000000, overflow=0; (2^31-1)*(-2^31) =
//    64'hC000000080000000, overflow=1; (-2^31)*(-2^31) = 64'h4000000000000000, overflow=1.
// CONFIGURATION
//  SHIFT_ADD_ZERO_SKIP_EN defined: if either latched operand is 0, IDLE goes directly to DONE;
//    done pulses in cycle after edge E1 with product=0, overflow=0.
//  Undefined: all operands take full WIDTH-iteration latency; results identical either way.
// TESTING
//  1. rst=0 mid-CALC -> product=0, done=0, overflow=0 immediately; no later done pulse.
//  2. 123*456 -> product=56088, overflow=0; done one cycle, exactly WIDTH+1 edges after start edge.
//  3. -123*456 -> 64'hFFFFFFFFFFFF24E8 (-56088); -123*-456 -> 56088; -5*-7 -> 35; -5*7 -> -35.
//  4. 12345*0 and 0*12345 -> 0, overflow=0; latency 1 edge with SHIFT_ADD_ZERO_SKIP_EN, else WIDTH+1.
//  5. 32'h7FFFFFFF*2 -> 64'h00000000FFFFFFFE, overflow=1; 32'h80000000*1 -> 64'hFFFFFFFF80000000, ov=0.
//  6. 32'h7FFFFFFF*32'h80000000 -> 64'hC000000080000000, overflow=1; start pulsed during CALC ignored.

Source files
------------

// File: rtl/shift_add_multiplier.sv
// Sequential signed multiplier: sign-magnitude shift-and-add, one partial product per clock.
// Optional macro SHIFT_ADD_ZERO_SKIP_EN: a zero operand skips the iteration phase entirely.
module shift_add_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 done,
  output logic                 overflow
);

  // state  | meaning
  // S_IDLE | waiting for start; product/overflow hold last result
  // S_CALC | one conditional add of the shifted multiplicand per clock
  // S_DONE | apply sign, register product/overflow, pulse done

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_mcand_sh;
  logic [WIDTH:0]   r_mplier_mag;
  logic             r_sign;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]   w_a_ext;
  logic [WIDTH:0]   w_b_ext;
  logic [WIDTH:0]   w_a_mag;
  logic [WIDTH:0]   w_b_mag;
  logic [PW-1:0]    w_addend;
  logic [PW-1:0]    w_acc_next;
  logic [PW-1:0]    w_prod;
  logic             w_ov;
  logic             w_last_step;

  // One extra magnitude bit keeps |-2^(WIDTH-1)| exact.
  assign w_a_ext  = {multiplicand[WIDTH-1], multiplicand};
  assign w_b_ext  = {multiplier[WIDTH-1], multiplier};
  assign w_a_mag  = multiplicand[WIDTH-1] ? (~w_a_ext + {{WIDTH{1'b0}}, 1'b1}) : w_a_ext;
  assign w_b_mag  = multiplier[WIDTH-1]   ? (~w_b_ext + {{WIDTH{1'b0}}, 1'b1}) : w_b_ext;

  assign w_addend    = r_mplier_mag[0] ? r_mcand_sh : '0;
  assign w_acc_next  = r_acc + w_addend;
  assign w_last_step = (r_cnt == CW'(WIDTH - 1));

  // Negating a zero accumulator yields zero, so no negative-zero special case.
  assign w_prod = r_sign ? (~r_acc + PW'(1)) : r_acc;
  assign w_ov   = ~((&w_prod[PW-1:WIDTH-1]) | ~(|w_prod[PW-1:WIDTH-1]));

`ifdef SHIFT_ADD_ZERO_SKIP_EN
  logic w_zero_op;
  assign w_zero_op = ~(|multiplicand) | ~(|multiplier);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_acc        <= '0;
      r_mcand_sh   <= '0;
      r_mplier_mag <= '0;
      r_sign       <= 1'b0;
      r_cnt        <= '0;
      product      <= '0;
      done         <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand_sh   <= {{(WIDTH-1){1'b0}}, w_a_mag};
            r_mplier_mag <= w_b_mag;
            r_sign       <= multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
            r_acc        <= '0;
            r_cnt        <= '0;
`ifdef SHIFT_ADD_ZERO_SKIP_EN
            r_state      <= w_zero_op ? S_DONE : S_CALC;
`else
            r_state      <= S_CALC;
`endif
          end
        end
        S_CALC: begin
          r_acc        <= w_acc_next;
          r_mcand_sh   <= r_mcand_sh << 1;
          r_mplier_mag <= r_mplier_mag >> 1;
          r_cnt        <= r_cnt + CW'(1);
          if (w_last_step) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          product  <= w_prod;
          overflow <= w_ov;
          done     <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: arithmetic model plus per-cycle output compare.
module tb_shift_add_multiplier;
  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic [2*W-1:0] product;
  logic           done;
  logic           overflow;

  int errors = 0;
  int checks = 0;

  logic [2*W-1:0] m_prod;
  logic           m_ov;
  logic [2*W-1:0] m_held_prod;
  logic           m_held_ov;
  bit             m_pending;
  int             m_edges;
  int             m_lat;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .done         (done),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Signed product and overflow straight from integer arithmetic.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p      = longint'($signed(a)) * longint'($signed(b));
    m_prod = p;
    m_ov   = (p > 64'sd2147483647) || (p < -64'sd2147483648);
`ifdef SHIFT_ADD_ZERO_SKIP_EN
    m_lat  = (a == '0 || b == '0) ? 1 : W + 1;
`else
    m_lat  = W + 1;
`endif
  endtask

  // Every cycle out of reset: done only when expected, with the right latency and
  // value; otherwise product/overflow must hold the last result.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      if (m_pending) m_edges++;
      if (done) begin
        if (!m_pending) begin
          chk("spurious_done", 64'(done), 64'(0));
        end else begin
          chk("latency", 64'(m_edges - 1), 64'(m_lat));
          chk("product", product, m_prod);
          chk("overflow", 64'(overflow), 64'(m_ov));
          m_held_prod = m_prod;
          m_held_ov   = m_ov;
          m_pending   = 1'b0;
        end
      end else begin
        chk("product_hold", product, m_held_prod);
        chk("overflow_hold", 64'(overflow), 64'(m_held_ov));
        if (m_pending && (m_edges - 1) > m_lat) begin
          chk("done_timeout", 64'(m_edges - 1), 64'(m_lat));
          m_pending = 1'b0;
        end
      end
    end
  end

  task automatic mul(input logic [W-1:0] a, input logic [W-1:0] b,
                     input bit use_lit, input logic [63:0] lit_p, input bit lit_ov,
                     input bit inject_start);
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    model(a, b);
    m_edges   = 0;
    m_pending = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
    if (inject_start) begin
      repeat (4) @(negedge clk);
      multiplicand = 32'd1;
      multiplier   = 32'd1;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 200 && m_pending; i++) @(negedge clk);
    if (m_pending) begin
      chk("wait_done", 64'(m_pending), 64'(0));
      m_pending = 1'b0;
    end
    if (use_lit) begin
      chk("lit_product", product, lit_p);
      chk("lit_overflow", 64'(overflow), 64'(lit_ov));
    end
    @(negedge clk);
  endtask

  initial begin
    rst          = 1'b0;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    m_pending    = 1'b0;
    m_edges      = 0;
    m_lat        = 0;
    m_prod       = '0;
    m_ov         = 1'b0;
    m_held_prod  = '0;
    m_held_ov    = 1'b0;

    #2;
    chk("rst_product", product, 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    mul(32'd123, 32'd456, 1, 64'd56088, 0, 0);

    // Abort mid-calculation: outputs clear at once and no done follows.
    mul(32'h7FFFFFFF, 32'd2, 1, 64'h00000000FFFFFFFE, 1, 0);
    @(negedge clk);
    multiplicand = 32'd77;
    multiplier   = 32'd99;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst         = 1'b0;
    m_held_prod = '0;
    m_held_ov   = 1'b0;
    #1;
    chk("abort_product", product, 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_overflow", 64'(overflow), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (50) @(negedge clk);

    mul(-32'sd123, 32'd456,      1, 64'hFFFFFFFFFFFF24E8, 0, 0);
    mul(-32'sd123, -32'sd456,    1, 64'd56088, 0, 0);
    mul(-32'sd5,   -32'sd7,      1, 64'd35, 0, 0);
    mul(-32'sd5,   32'd7,        1, 64'hFFFFFFFFFFFFFFDD, 0, 0);
    mul(32'd12345, 32'd0,        1, 64'd0, 0, 0);
    mul(32'd0,     32'd12345,    1, 64'd0, 0, 0);
    mul(-32'sd9,   32'd0,        1, 64'd0, 0, 0);
    mul(32'h80000000, 32'd1,     1, 64'hFFFFFFFF80000000, 0, 0);
    mul(32'h7FFFFFFF, 32'h80000000, 1, 64'hC000000080000000, 1, 1);
    mul(32'h80000000, 32'h80000000, 1, 64'h4000000000000000, 1, 0);
    mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 64'd1, 0, 0);
    mul(32'h0000FFFF, 32'h00010001, 1, 64'h00000000FFFFFFFF, 1, 0);
    for (int k = 0; k < 4; k++) begin
      mul($urandom, $urandom, 0, 64'd0, 0, 0);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
